// File: rtl/mem_read_ctrl.sv
// Memory read controller: fetches one word per rd_start, waits for a variable-latency
// acknowledge, latches the data into mdr_q and reports done or timeout.
module mem_read_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_start,
  input  logic [31:0]       addr_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // The last WAIT count before abort; TIMEOUT <= 255 keeps this below the 8-bit wrap point.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;

  // Upper CPU-bus address bits do not reach the 512-word RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_in[31:ADDR_W];

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mdr_q     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rd_start) begin
            mem_addr  <= addr_in[ADDR_W-1:0];
            mem_rd    <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // An acknowledge on the final allowed edge still counts as success.
          if (mem_ack) begin
            mdr_q     <= mem_data;
            mem_rd    <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            mem_rd    <= 1'b0;
            err       <= 1'b1;
            state_reg <= ERR;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        ERR: begin
          err       <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Self-checking bench for mem_read_ctrl: directed scenarios plus random reads,
// checked against a transaction-level timeline model.
module tb_mem_read_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              clr;
  logic              rd_start;
  logic [31:0]       addr_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mdr_q;
  logic              busy;
  logic              done;
  logic              err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: what the read path should currently be holding.
  logic [DATA_W-1:0] exp_mdr  = '0;
  logic [ADDR_W-1:0] exp_addr = '0;

  mem_read_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .rd_start(rd_start),
    .addr_in (addr_in),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_ack (mem_ack),
    .mem_data(mem_data),
    .mdr_q   (mdr_q),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string ph, input logic e_rd, input logic e_done,
                            input logic e_err, input logic e_busy);
    check({ph, ".mem_rd"},   32'(mem_rd),   32'(e_rd));
    check({ph, ".done"},     32'(done),     32'(e_done));
    check({ph, ".err"},      32'(err),      32'(e_err));
    check({ph, ".busy"},     32'(busy),     32'(e_busy));
    check({ph, ".mdr_q"},    mdr_q,         exp_mdr);
    check({ph, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One read whose acknowledge arrives on WAIT edge 'delay' (1 = zero-wait).
  // A delay beyond TIMEOUT means no ack in time; TIMEOUT+1 lands as a late ack in ERR.
  task automatic do_read(input logic [31:0] addr, input int delay,
                         input logic [31:0] data, input bit poke_start);
    int f0;
    string outcome;
    f0 = n_fail;
    rd_start = 1'b1;
    addr_in  = addr;
    mem_ack  = 1'b0;
    step();
    rd_start = 1'b0;
    exp_addr = addr[ADDR_W-1:0];
    check_outs("issue", 1'b1, 1'b0, 1'b0, 1'b1);
    outcome = "timeout";
    for (int k = 1; k <= TIMEOUT; k++) begin
      rd_start = poke_start ? 1'b1 : 1'($urandom_range(0, 1));
      addr_in  = $urandom;
      mem_ack  = (k == delay);
      mem_data = (k == delay) ? data : $urandom;
      step();
      mem_ack = 1'b0;
      if (k == delay) begin
        exp_mdr = data;
        outcome = "done";
        check_outs("ack", 1'b0, 1'b1, 1'b0, 1'b1);
        break;
      end else if (k == TIMEOUT) begin
        check_outs("timeout", 1'b0, 1'b0, 1'b1, 1'b1);
        break;
      end else begin
        check_outs("wait", 1'b1, 1'b0, 1'b0, 1'b1);
      end
    end
    // Retire edge: a fresh request and any late ack must be ignored.
    rd_start = 1'b1;
    addr_in  = $urandom;
    mem_ack  = (delay == TIMEOUT + 1);
    mem_data = $urandom;
    step();
    rd_start = 1'b0;
    mem_ack  = 1'b0;
    check_outs("retire", 1'b0, 1'b0, 1'b0, 1'b0);
    // Idle edge: stray acks do nothing.
    mem_ack  = 1'($urandom_range(0, 1));
    mem_data = $urandom;
    step();
    mem_ack = 1'b0;
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("read addr=%h delay=%0d -> %s mdr_q=%h errors=%0d",
             addr, delay, outcome, mdr_q, n_fail - f0);
  endtask

  initial begin
    clr      = 1'b1;
    rd_start = 1'b0;
    addr_in  = '0;
    mem_ack  = 1'b0;
    mem_data = '0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    clr      = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    check_outs("idle_ack", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("reset then idle ack: errors=%0d", n_fail);

    do_read(32'h0000_0A3C, 1, 32'hDEAD_BEEF, 1'b0);
    do_read($urandom, 6, 32'd30, 1'b1);
    do_read($urandom, TIMEOUT + 1, 32'd99, 1'b0);
    do_read($urandom, TIMEOUT, 32'd50, 1'b0);

    // Reset in the middle of WAIT.
    rd_start = 1'b1;
    addr_in  = 32'h0000_0155;
    step();
    rd_start = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr      = 1'b0;
    exp_mdr  = '0;
    exp_addr = '0;
    check_outs("mid_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("clear during wait: mem_rd=%b mdr_q=%h busy=%b", mem_rd, mdr_q, busy);
    do_read(32'h0000_0123, 3, 32'd20, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_read($urandom, int'($urandom_range(1, TIMEOUT + 3)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
